// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver: 5-8 data bits, optional parity, 1 or 2 stop bits.
// Received bytes go to a write port; parity/framing/overrun errors are one-cycle pulses.
module uart_rx_os16 #(
    parameter int DIVISOR = 326
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [3:0] num_data_bits,
    input  logic       stop_bits,
    input  logic [1:0] parity,
    output logic [7:0] rx_data,
    output logic       rx_wren,
    input  logic       rx_full,
    output logic       rx_busy,
    output logic       parity_error,
    output logic       framing_error,
    output logic       overrun_error
);

    localparam int PW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, rxs_q, rxs_prev_q;
    logic [PW-1:0]   pre_q, pre_d;
    logic [3:0]      sub_q, sub_d;
    logic            samp7_q, samp7_d, samp8_q, samp8_d;
    logic [3:0]      nbits_q, nbits_d;
    logic            par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            ones_q, ones_d, perr_q, perr_d, ferr_q, ferr_d;

    logic            det, tick, decide, bit_val, par_total;

    assign det     = (state_q == S_IDLE) && rxs_prev_q && !rxs_q;
    assign tick    = (pre_q == PW'(DIVISOR - 1));
    assign decide  = tick && (sub_q == 4'd8);
    assign bit_val = (samp7_q & samp8_q) | (samp7_q & rxs_q) | (samp8_q & rxs_q);
    // Running parity over data plus the parity bit itself; 1 means an odd ones count.
    assign par_total = ones_q ^ bit_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            pre_q      <= '0;
            sub_q      <= '0;
            samp7_q    <= 1'b1;
            samp8_q    <= 1'b1;
            nbits_q    <= 4'd8;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ones_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= rx;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            pre_q      <= pre_d;
            sub_q      <= sub_d;
            samp7_q    <= samp7_d;
            samp8_q    <= samp8_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ones_q     <= ones_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_d     = tick ? '0 : pre_q + PW'(1);
        sub_d     = tick ? sub_q + 4'd1 : sub_q;
        samp7_d   = (tick && sub_q == 4'd6) ? rxs_q : samp7_q;
        samp8_d   = (tick && sub_q == 4'd7) ? rxs_q : samp8_q;
        nbits_d   = nbits_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ones_d    = ones_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        case (state_q)
            S_IDLE: begin
                if (det) begin
                    state_d   = S_START;
                    pre_d     = '0;
                    sub_d     = '0;
                    nbits_d   = (num_data_bits >= 4'd5 && num_data_bits <= 4'd8) ? num_data_bits : 4'd8;
                    par_en_d  = (parity == 2'd1) || (parity == 2'd2);
                    par_odd_d = (parity == 2'd2);
                    stop2_d   = stop_bits;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    ones_d    = 1'b0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            S_START: begin
                if (decide) begin
                    state_d = bit_val ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d   = {bit_val, shift_q[7:1]};
                    ones_d    = ones_q ^ bit_val;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(nbits_q - 4'd1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    perr_d  = par_total ^ par_odd_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    if (!bit_val) begin
                        ferr_d = 1'b1;
                    end
                    if (stop2_q && bit_cnt_q == 3'd0) begin
                        bit_cnt_d = 3'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            // A line still low after the frame is a break; park until it releases.
            S_DONE:  state_d = rxs_q ? S_IDLE : S_BREAK;
            S_BREAK: state_d = rxs_q ? S_IDLE : S_BREAK;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_wren       = 1'b0;
        rx_data       = '0;
        parity_error  = 1'b0;
        framing_error = 1'b0;
        overrun_error = 1'b0;
        rx_busy       = (state_q != S_IDLE);
        if (state_q == S_DONE) begin
            rx_wren       = !rx_full;
            rx_data       = shift_q >> (4'd8 - nbits_q);
            parity_error  = perr_q;
            framing_error = ferr_q;
            overrun_error = rx_full;
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: directed frames plus randomized frames
// checked against a frame-level model of expected strobes, data, errors and timing.
module tb_uart_rx_os16;

    localparam int DIV = 2;
    localparam int BIT = 16 * DIV;

    typedef struct packed {
        int         cyc;
        logic       wren;
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       oe;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst, rx, stop_bits, rx_full;
    logic [3:0] num_data_bits;
    logic [1:0] parity;
    logic [7:0] rx_data;
    logic       rx_wren, rx_busy, parity_error, framing_error, overrun_error;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    ev_t evq[$];

    uart_rx_os16 #(.DIVISOR(DIV)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .num_data_bits (num_data_bits),
        .stop_bits     (stop_bits),
        .parity        (parity),
        .rx_data       (rx_data),
        .rx_wren       (rx_wren),
        .rx_full       (rx_full),
        .rx_busy       (rx_busy),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        ev_t e;
        if (!rst && (rx_wren || parity_error || framing_error || overrun_error)) begin
            e.cyc  = cyc;
            e.wren = rx_wren;
            e.data = rx_data;
            e.pe   = parity_error;
            e.fe   = framing_error;
            e.oe   = overrun_error;
            evq.push_back(e);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic s2);
        num_data_bits = nb;
        parity        = par;
        stop_bits     = s2;
    endtask

    // Frame-level model: expected outputs follow from the bit list and the framing rules.
    task automatic send_frame(input logic [7:0] data, input logic [3:0] nb_raw, input logic [1:0] par,
                              input logic stop2, input bit bad_par, input bit [1:0] stop_lo,
                              input bit full, input bit scramble, input int gap_in);
        int         nb, ones, total, t0, k, gap;
        bit         pen, podd, pbit, exp_pe, exp_fe, last_low;
        logic [7:0] dexp;
        bit         bits[$];
        nb   = (nb_raw >= 5 && nb_raw <= 8) ? int'(nb_raw) : 8;
        pen  = (par == 2'd1) || (par == 2'd2);
        podd = (par == 2'd2);
        dexp = '0;
        for (int i = 0; i < nb; i++) dexp[i] = data[i];
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(data[i]);
        ones   = $countones(dexp);
        exp_pe = 1'b0;
        if (pen) begin
            pbit = podd ? (ones % 2 == 0) : (ones % 2 == 1);
            if (bad_par) pbit = !pbit;
            bits.push_back(pbit);
            total  = ones + int'(pbit);
            exp_pe = podd ? (total % 2 == 0) : (total % 2 == 1);
        end
        bits.push_back(!stop_lo[0]);
        if (stop2) bits.push_back(!stop_lo[1]);
        exp_fe   = stop_lo[0] || (stop2 && stop_lo[1]);
        last_low = !bits[bits.size() - 1];
        gap      = (last_low && gap_in < 8) ? 8 : gap_in;
        k        = bits.size() - 1;

        set_cfg(nb_raw, par, stop2);
        rx_full = full;
        t0 = cyc;
        foreach (bits[i]) begin
            rx = bits[i];
            if (scramble && i == 2) set_cfg(4'($urandom), 2'($urandom), 1'($urandom));
            repeat (BIT) tick();
        end
        rx      = 1'b1;
        rx_full = 1'b0;

        check_eq("ev_count", evq.size(), 1);
        if (evq.size() > 0) begin
            check_eq("ev_cycle", evq[0].cyc - t0, 3 + DIV * (16 * k + 9));
            check_eq("rx_wren", evq[0].wren, !full);
            check_eq("rx_data", evq[0].data, dexp);
            check_eq("parity_error", evq[0].pe, exp_pe);
            check_eq("framing_error", evq[0].fe, exp_fe);
            check_eq("overrun_error", evq[0].oe, full);
        end
        if (!last_low) check_eq("busy_after_frame", rx_busy, 0);
        $display("frame data=%02h nb=%0d par=%0d stop2=%0d stop_lo=%0b full=%0d scr=%0d exp=%02h pe=%0d fe=%0d",
                 data, nb, par, stop2, stop_lo, full, scramble, dexp, exp_pe, exp_fe);
        evq.delete();
        repeat (gap) tick();
    endtask

    task automatic do_glitch();
        int t0;
        set_cfg(4'd8, 2'd0, 1'b0);
        t0 = cyc;
        rx = 1'b0;
        repeat (3) tick();
        check_eq("glitch_busy_rise", rx_busy, 1);
        repeat (2) tick();
        rx = 1'b1;
        while (cyc < t0 + 2 + 9 * DIV) tick();
        check_eq("glitch_busy_at_decision", rx_busy, 1);
        tick();
        check_eq("glitch_busy_fall", rx_busy, 0);
        repeat (BIT) tick();
        check_eq("glitch_no_event", evq.size(), 0);
        $display("glitch t0=%0d busy=%0d events=%0d", t0, rx_busy, evq.size());
        evq.delete();
    endtask

    task automatic do_break();
        int t0;
        set_cfg(4'd8, 2'd0, 1'b0);
        t0 = cyc;
        rx = 1'b0;
        repeat (20 * BIT) tick();
        check_eq("brk_ev_count", evq.size(), 1);
        if (evq.size() > 0) begin
            check_eq("brk_ev_cycle", evq[0].cyc - t0, 3 + DIV * (16 * 9 + 9));
            check_eq("brk_wren", evq[0].wren, 1);
            check_eq("brk_data", evq[0].data, 0);
            check_eq("brk_fe", evq[0].fe, 1);
            check_eq("brk_pe", evq[0].pe, 0);
        end
        check_eq("brk_busy_held", rx_busy, 1);
        evq.delete();
        rx = 1'b1;
        repeat (6) tick();
        check_eq("brk_busy_release", rx_busy, 0);
        repeat (BIT) tick();
        check_eq("brk_quiet", evq.size(), 0);
        $display("break t0=%0d busy=%0d", t0, rx_busy);
        evq.delete();
    endtask

    task automatic do_reset_mid();
        set_cfg(4'd8, 2'd0, 1'b0);
        rx = 1'b0;
        repeat (BIT) tick();
        rx = 1'b1;
        repeat (2 * BIT) tick();
        check_eq("rstm_busy_before", rx_busy, 1);
        rst = 1'b1;
        #1;
        check_eq("rstm_busy", rx_busy, 0);
        check_eq("rstm_wren_data", {rx_wren, rx_data}, 0);
        check_eq("rstm_errors", {parity_error, framing_error, overrun_error}, 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (12 * BIT) tick();
        check_eq("rstm_no_event", evq.size(), 0);
        check_eq("rstm_idle", rx_busy, 0);
        $display("reset mid-frame busy=%0d events=%0d", rx_busy, evq.size());
        evq.delete();
    endtask

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        rx_full = 1'b0;
        set_cfg(4'd8, 2'd0, 1'b0);
        repeat (3) tick();
        check_eq("reset_busy", rx_busy, 0);
        check_eq("reset_wren", rx_wren, 0);
        check_eq("reset_data", rx_data, 0);
        check_eq("reset_errors", {parity_error, framing_error, overrun_error}, 0);
        rst = 1'b0;
        repeat (4) tick();
        check_eq("post_reset_busy", rx_busy, 0);
        check_eq("post_reset_wren_data", {rx_wren, rx_data}, 0);
        $display("reset busy=%0d wren=%0d data=%02h", rx_busy, rx_wren, rx_data);

        send_frame(8'hA5, 4'd8, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5);
        send_frame(8'h35, 4'd7, 2'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 10);
        send_frame(8'hFF, 4'd8, 2'd2, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5);
        do_glitch();
        send_frame(8'h3C, 4'd8, 2'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 0);
        send_frame(8'hC3, 4'd8, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5);
        do_break();
        do_reset_mid();
        send_frame(8'h5A, 4'd8, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3);

        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                       ($urandom_range(0, 4) == 0), 1'($urandom),
                       $urandom_range(0, 10));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

Standalone 16x-oversampling UART receiver running entirely in the system `clk` domain, so no handshake synchronizer is needed toward the 8-to-24 combiner. It deserializes 5–8 data bits with optional parity and 1 or 2 stop bits. Each received byte is pushed to a downstream write port, and parity, framing and overrun errors are reported as one-cycle pulses. It is the receive-side counterpart to the peripheral's transmit path. It slots between the `in[0]` pin and the rx byte combiner.

## Interface
- `DIVISOR`, default 326: `clk` cycles per oversample tick. 326 gives 16x at 9600 baud from 50 MHz. Minimum 1.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `rx` input 1: serial line, asynchronous, idle high.
- `num_data_bits` input 4: 5..8; any other value is treated as 8.
- `stop_bits` input 1: 0 = one stop bit, 1 = two stop bits.
- `parity` input 2: 0 = none, 1 = even, 2 = odd, 3 = none.
- `rx_data` output 8: received byte, LSB first on the wire; unused upper bits are 0.
- `rx_wren` output 1: one-cycle write strobe; `rx_data` is valid in the same cycle.
- `rx_full` input 1: downstream full; sampled only in the cycle `rx_wren` would assert.
- `rx_busy` output 1: high in every state except IDLE.
- `parity_error`, `framing_error`, `overrun_error` output 1 each: one-cycle pulses.

## Operation
- **Synchronizer.** `rx` passes through a 2-flop synchronizer whose flops reset to 1. All logic uses the synchronized value `rxs`.
- **Prescaler.** Counts 0..DIVISOR-1 and emits a tick at wrap. It is forced to 0 on start detection, so tick n falls at det+n·DIVISOR.
- **Bit sub-counter.** Counts 0..15 in ticks. Within each bit the block takes samples at counts 7, 8 and 9. The bit value is the majority of the three, decided at count 9.
- **Config latch.** `num_data_bits`, `parity` and `stop_bits` are latched at start detection and held for the whole frame.
- **IDLE.** A high-to-low transition on `rxs` is start detection. "det" is that cycle, which is also sub-tick 0.
- **START.** Decided bit 1 is a false start: return to IDLE with no outputs. Decided bit 0 goes to DATA.
- **DATA.** Shift decided bits in LSB first. After N bits, go to PARITY if parity is enabled, otherwise to STOP.
- **PARITY.** Capture the bit. Even parity requires the ones count over data+parity to be even; odd parity requires it to be odd.
- **STOP.** Any stop bit decided 0 sets the framing error. With `stop_bits`=1 both stop bits are checked. At the final stop decision the block moves to DONE.
- **DONE** lasts one cycle:
  - If `rx_full`=0: `rx_wren`=1 and `rx_data` is driven. `parity_error` and `framing_error` pulse in that same cycle if set; a byte with errors is still written.
  - If `rx_full`=1: the byte is dropped, `rx_wren` stays 0, `overrun_error`=1, and parity/framing pulses still occur.
  - Next state is IDLE if `rxs`=1, otherwise BREAK.
- **BREAK.** Wait until `rxs`=1, then go to IDLE. This stops a held-low line from retriggering start detection.
- **Config changes** mid-frame have no effect until the next start.

## Timing
- **Reset values:** `rx_data`=0, `rx_wren`=0, `rx_busy`=0, all error outputs 0, state IDLE, synchronizer flops 1.
- **Decision timing:** the decision for bit k (k=0 is start) falls at det + DIVISOR·(16k+9). DONE, and `rx_wren` with it, comes 1 cycle after the last decision.
- **DIVISOR=1 example:** 8N1 gives `rx_wren` at det+154. With the 2-flop synchronizer that is 156 cycles after the `rx` pin falls.
- **Back-to-back frames:** the block is back in IDLE well before the end of the stop bit, so a start edge immediately after the stop bit is caught.
- **Reset mid-frame:** returns to IDLE immediately with no pulses.
- **rx_busy:** rises the cycle after det and falls on the cycle after DONE, or when BREAK exits.

## Test plan
- **8N1 byte:** DIVISOR=1, frame 0xA5 at 16 cycles/bit → `rx_wren` at det+154 with `rx_data`=0xA5 and no error pulses.
- **7E2 framing:** 7 data bits 0x35, even parity bit 0, two stop bits with the second forced low → `rx_data`=0x35, `rx_wren`=1, `framing_error`=1, `parity_error`=0.
- **Odd parity error:** 8O1 frame 0xFF with parity bit 0 (should be 1) → `parity_error`=1 alongside `rx_wren`.
- **Glitch rejection:** 5-cycle low glitch on `rx` → false start, no `rx_wren`, `rx_busy` back to 0 by det+10.
- **Overrun:** `rx_full`=1 during DONE of 0x3C → `rx_wren`=0, `overrun_error`=1. The following frame 0xC3 with `rx_full`=0 is written normally.
- **Break and reset:** hold `rx` low for 300 cycles → one `framing_error` with `rx_data`=0x00, then no new frame until `rx` rises. Asserting `rst` mid-DATA → all outputs 0 and IDLE.
